mem_block_responder: RTL and testbench

//  Memory-side responder for the 128-bit block interface driven by the L1 cache controller.

---
 rtl/mem_if_pkg.sv | 9 +
 rtl/mem_block_array.sv | 20 ++
 rtl/mem_block_responder.sv | 103 ++++++++++
 tb/tb_mem_block_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Block-interface definitions shared between the L1 cache controller and the memory responder.
package mem_if_pkg;
   localparam int ADDR_W  = 28;
   localparam int BLOCK_W = 128;
   localparam int WORD_W  = 32;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic       {CMD_RD, CMD_WR}   cmd_t;
endpackage

// File: rtl/mem_block_array.sv
// Single-port block storage: synchronous write, combinational read of the addressed block.
module mem_block_array #(
   parameter int IDX_W   = 10,
   parameter int BLOCK_W = 128
) (
   input  logic               clk,
   input  logic               i_we,
   input  logic [IDX_W-1:0]   i_idx,
   input  logic [BLOCK_W-1:0] i_wdata,
   output logic [BLOCK_W-1:0] o_rdata
);
   logic [BLOCK_W-1:0] r_mem [2**IDX_W];

   // Contents deliberately have no reset; they survive proc_reset.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_idx] <= i_wdata;
   end

   assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/mem_block_responder.sv
// Fixed-latency block memory responder: request latch, latency counter, IDLE/BUSY/DONE FSM.
module mem_block_responder
   import mem_if_pkg::*;
#(
   parameter int IDX_W   = 10,
   parameter int LATENCY = 8
) (
   input  logic               clk,
   input  logic               proc_reset,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [ADDR_W-1:0]  mem_addr,
   input  logic [BLOCK_W-1:0] mem_wdata,
   output logic               mem_ready,
   output logic [BLOCK_W-1:0] mem_rdata,
   output logic               proto_err
);
   state_t             r_state;
   cmd_t               r_cmd;
   logic [ADDR_W-1:0]  r_addr;
   logic [BLOCK_W-1:0] r_wdata;
   logic [7:0]         r_cnt;
   logic               r_ready;
   logic [BLOCK_W-1:0] r_rdata;
   logic               r_perr;

   logic               w_req;
   cmd_t               w_cmd;
   logic               w_same;
   logic               w_done;
   logic               w_we;
   logic [BLOCK_W-1:0] w_arr_rdata;

   // A simultaneous read+write is serviced as a write.
   assign w_req  = mem_read | mem_write;
   assign w_cmd  = mem_write ? CMD_WR : CMD_RD;
   assign w_same = (w_cmd == r_cmd) && (mem_addr == r_addr);
   assign w_done = (r_state == BUSY) && w_req && (r_cnt == 8'd0);
   assign w_we   = w_done && (r_cmd == CMD_WR);

   mem_block_array #(.IDX_W(IDX_W), .BLOCK_W(BLOCK_W)) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_idx   (r_addr[IDX_W-1:0]),
      .i_wdata (r_wdata),
      .o_rdata (w_arr_rdata)
   );

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         r_state <= IDLE;
         r_cmd   <= CMD_RD;
         r_addr  <= '0;
         r_wdata <= '0;
         r_cnt   <= 8'd0;
         r_ready <= 1'b0;
         r_rdata <= '0;
         r_perr  <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         if (mem_read && mem_write) r_perr <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_cmd   <= w_cmd;
                  r_addr  <= mem_addr;
                  r_wdata <= mem_wdata;
                  r_cnt   <= 8'(LATENCY - 1);
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (!w_req) begin
                  r_state <= IDLE;
               end else if (r_cnt != 8'd0) begin
                  r_cnt <= r_cnt - 8'd1;
               end else begin
                  r_ready <= 1'b1;
                  if (r_cmd == CMD_RD) r_rdata <= w_arr_rdata;
                  r_state <= DONE;
               end
            end
            DONE: begin
               // Initiator still holds the finished request while it registers mem_ready.
               if (!w_req) begin
                  r_state <= IDLE;
               end else if (!w_same) begin
                  r_cmd   <= w_cmd;
                  r_addr  <= mem_addr;
                  r_wdata <= mem_wdata;
                  r_cnt   <= 8'(LATENCY - 1);
                  r_state <= BUSY;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_ready = r_ready;
   assign mem_rdata = r_rdata;
   assign proto_err = r_perr;
endmodule

// File: tb/tb_mem_block_responder.sv
// Randomized + directed bench for mem_block_responder against a transaction-level memory model.
module tb_mem_block_responder;
   localparam int LAT0 = 8;
   localparam int LAT1 = 1;

   logic         clk = 1'b0;
   logic         proc_reset;
   logic         rd    [2];
   logic         wr    [2];
   logic [27:0]  addr  [2];
   logic [127:0] wdata [2];
   logic         ready [2];
   logic [127:0] rdata [2];
   logic         perr  [2];

   int           lat [2] = '{LAT0, LAT1};
   bit [127:0]   mdl [2][1024];
   bit           wok [2][1024];
   bit [127:0]   last_rd [2];
   bit           perr_m [2];
   int           n_chk = 0;
   int           n_fail = 0;

   always #5 clk = ~clk;

   mem_block_responder u_dut0 (
      .clk(clk), .proc_reset(proc_reset), .mem_read(rd[0]), .mem_write(wr[0]),
      .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_ready(ready[0]),
      .mem_rdata(rdata[0]), .proto_err(perr[0]));

   mem_block_responder #(.LATENCY(LAT1)) u_dut1 (
      .clk(clk), .proc_reset(proc_reset), .mem_read(rd[1]), .mem_write(wr[1]),
      .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_ready(ready[1]),
      .mem_rdata(rdata[1]), .proto_err(perr[1]));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int d, input int n);
      rd[d] = 1'b0; wr[d] = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("idle_no_ready", 128'(ready[d]), 128'(0));
      end
   endtask

   // kind: 0 read, 1 write, 2 read+write. Request is held for `hold` cycles past the ready pulse.
   task automatic xact(input int d, input int kind, input logic [27:0] a,
                       input logic [127:0] wd, input int hold);
      int k_obs = 0;
      int idx = int'(a[9:0]);
      rd[d] = (kind != 1); wr[d] = (kind != 0); addr[d] = a; wdata[d] = wd;
      if (kind == 2) perr_m[d] = 1'b1;
      for (int k = 1; k <= lat[d] + 20; k++) begin
         @(negedge clk);
         if (ready[d]) begin k_obs = k; break; end
      end
      if (k_obs == 0) begin
         chk("ready_timeout", 128'(0), 128'(1));
      end else begin
         // ready is high in the cycle after edge accept+LATENCY
         chk("ready_cycle", 128'(k_obs), 128'(lat[d] + 1));
         if (kind == 0) last_rd[d] = mdl[d][idx];
         else begin mdl[d][idx] = wd; wok[d][idx] = 1'b1; end
         chk("rdata", rdata[d], last_rd[d]);
         chk("proto_err", 128'(perr[d]), 128'(perr_m[d]));
      end
      repeat (hold) begin
         @(negedge clk);
         chk("ready_single_pulse", 128'(ready[d]), 128'(0));
      end
   endtask

   task automatic xabort(input int d, input logic [27:0] a);
      int j = $urandom_range(1, lat[d] - 1);
      rd[d] = 1'b1; wr[d] = 1'b0; addr[d] = a;
      repeat (j) begin
         @(negedge clk);
         chk("abort_no_ready", 128'(ready[d]), 128'(0));
      end
      idle(d, lat[d] + 2);
      chk("abort_rdata_held", rdata[d], last_rd[d]);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] d7, d12, d5;
      int pool [8] = '{5, 7, 'h10, 'h12, 'h34, 'h3FF, 0, 'h200};
      bit pv = 1'b0; bit pw = 1'b0; logic [27:0] pa = '0;

      for (int d = 0; d < 2; d++) begin
         rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
         last_rd[d] = '0; perr_m[d] = 1'b0;
      end
      proc_reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_ready", 128'(ready[d]), 128'(0));
         chk("reset_rdata", rdata[d], 128'(0));
         chk("reset_perr", 128'(perr[d]), 128'(0));
      end
      proc_reset = 1'b0;
      idle(0, 2);

      // preload and test 1: read 0x5
      xact(0, 1, 28'h0000005, {32{4'hA}}, 0); idle(0, 1);
      xact(0, 1, 28'h0000034, rnd128(), 0);   idle(0, 1);
      xact(0, 0, 28'h0000005, '0, 0);         idle(0, 1);
      chk("t1_rdata_A", rdata[0], {32{4'hA}});

      // test 2: write held two cycles past ready, then read back-to-back
      xact(0, 1, 28'h0000010, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2);
      xact(0, 0, 28'h0000010, '0, 2);
      idle(0, 1);
      chk("t2_readback", rdata[0], 128'h1111_2222_3333_4444_5555_6666_7777_8888);

      // test 3: write-back then miss with no idle cycle in between
      d12 = rnd128();
      xact(0, 1, 28'h0000012, d12, 0);
      xact(0, 0, 28'h0000034, '0, 1);
      xact(0, 0, 28'h0000012, '0, 0);
      idle(0, 1);
      chk("t3_wb_data", rdata[0], d12);

      // test 5: read+write together is a write and sets sticky proto_err
      xact(0, 2, 28'h0000020, rnd128(), 1);
      idle(0, 2);
      chk("t5_perr_sticky", 128'(perr[0]), 128'(1));

      // test 4: reset at cnt=3 of a write to 0x7 must not commit
      d7 = rnd128();
      xact(0, 1, 28'h0000007, d7, 0); idle(0, 1);
      rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 28'h0000007; wdata[0] = ~d7;
      repeat (5) begin
         @(negedge clk);
         chk("t4_no_ready", 128'(ready[0]), 128'(0));
      end
      #2 proc_reset = 1'b1;
      rd[0] = 1'b0; wr[0] = 1'b0;
      for (int d = 0; d < 2; d++) begin last_rd[d] = '0; perr_m[d] = 1'b0; end
      @(negedge clk);
      chk("t4_reset_ready", 128'(ready[0]), 128'(0));
      chk("t4_reset_perr", 128'(perr[0]), 128'(0));
      proc_reset = 1'b0;
      idle(0, 2);
      xact(0, 0, 28'h0000007, '0, 0); idle(0, 1);
      chk("t4_array_unchanged", rdata[0], d7);

      // test 6: withdrawal, alias, LATENCY=1
      xabort(0, 28'h0000010);
      xact(0, 0, 28'h0400005, '0, 0); idle(0, 1);
      chk("t6_alias", rdata[0], {32{4'hA}});
      d5 = rnd128();
      xact(1, 1, 28'h0000005, d5, 0); idle(1, 1);
      xact(1, 0, 28'h0400005, '0, 2); idle(1, 1);
      chk("t6_lat1_alias", rdata[1], d5);

      // randomized traffic on both instances
      for (int d = 0; d < 2; d++) begin
         pv = 1'b0;
         for (int n = 0; n < 40; n++) begin
            int kind = $urandom_range(0, 9);
            int idx = pool[$urandom_range(0, 7)];
            logic [27:0] a = 28'(idx) | (28'($urandom_range(0, 3)) << 10);
            kind = (kind < 5) ? 0 : (kind < 9) ? 1 : 2;
            if (kind == 0 && !wok[d][idx]) kind = 1;
            if (d == 0 && $urandom_range(0, 7) == 0) begin
               idle(d, 1);
               xabort(d, a);
               pv = 1'b0;
               continue;
            end
            // same cmd and addr must not follow back-to-back
            if (pv && (pw == (kind != 0)) && (pa == a)) begin idle(d, 1); pv = 1'b0; end
            if ($urandom_range(0, 2) == 0) begin idle(d, $urandom_range(1, 2)); pv = 1'b0; end
            xact(d, kind, a, rnd128(), $urandom_range(0, 3));
            pv = 1'b1; pw = (kind != 0); pa = a;
         end
         idle(d, 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
